// File: rtl/clock_generator_pkg.sv
// Shared constants for the SAP-1 clock generator: FSM state codes and speed width.
package clock_generator_pkg;

   localparam int SPEED_BITS = 2;

   typedef enum logic [2:0] {
      CLK_ST_STOPPED  = 3'd0,
      CLK_ST_RUNNING  = 3'd1,
      CLK_ST_STOPPING = 3'd2,
      CLK_ST_STEP_HI  = 3'd3,
      CLK_ST_STEP_LO  = 3'd4
   } clk_state_e;

endpackage

// File: rtl/clock_generator_button_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// press pulse on each accepted 0->1 level change.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 25
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_press
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   // The level only moves after r_sync[1] has disagreed with it for
   // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= 2'b00;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_btn};
         r_press <= 1'b0;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt >= LP_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_press <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/clock_generator.sv
// SAP-1 system clock: run/stop, single-step and four-speed divider driven by
// debounced pushbuttons, with a registered, glitch-free clk output.
module clock_generator
   import clock_generator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DIV0            = 25000000,
   parameter int DIV1            = 2500000,
   parameter int DIV2            = 250000,
   parameter int DIV3            = 25,
   parameter int CNT_W           = 25
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clk_start_stop_i,
   input  logic                  clk_step_i,
   input  logic                  clk_speed_i,
   output logic                  clk,
   output logic                  clk_rise,
   output logic                  running,
   output logic [SPEED_BITS-1:0] speed,
   output clk_state_e            dbg_state
);

   localparam logic [CNT_W-1:0] LP_LAST0 = CNT_W'(DIV0 - 1);
   localparam logic [CNT_W-1:0] LP_LAST1 = CNT_W'(DIV1 - 1);
   localparam logic [CNT_W-1:0] LP_LAST2 = CNT_W'(DIV2 - 1);
   localparam logic [CNT_W-1:0] LP_LAST3 = CNT_W'(DIV3 - 1);

   logic                  w_ss_press;
   logic                  w_step_press;
   logic                  w_speed_press;
   logic [CNT_W-1:0]      w_last;
   logic                  w_term;

   clk_state_e            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_clk;
   logic                  r_clk_rise;
   logic [SPEED_BITS-1:0] r_speed;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_ss (
      .i_clk(clk_i), .i_rst_n(rst_i), .i_btn(clk_start_stop_i), .o_press(w_ss_press)
   );
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_step (
      .i_clk(clk_i), .i_rst_n(rst_i), .i_btn(clk_step_i), .o_press(w_step_press)
   );
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_speed (
      .i_clk(clk_i), .i_rst_n(rst_i), .i_btn(clk_speed_i), .o_press(w_speed_press)
   );

   always_comb begin
      w_last = LP_LAST0;
      case (r_speed)
         2'd1:    w_last = LP_LAST1;
         2'd2:    w_last = LP_LAST2;
         2'd3:    w_last = LP_LAST3;
         default: w_last = LP_LAST0;
      endcase
   end

   // >= rather than == so a mid-phase switch to a faster speed ends the phase at once.
   assign w_term = (r_cnt >= w_last);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= CLK_ST_STOPPED;
         r_cnt      <= '0;
         r_clk      <= 1'b0;
         r_clk_rise <= 1'b0;
         r_speed    <= '0;
      end else begin
         r_clk_rise <= 1'b0;
         if (w_speed_press) r_speed <= r_speed + SPEED_BITS'(1);
         case (r_state)
            CLK_ST_STOPPED: begin
               r_cnt <= '0;
               r_clk <= 1'b0;
               if (w_ss_press) begin
                  r_state <= CLK_ST_RUNNING;
               end else if (w_step_press) begin
                  r_state    <= CLK_ST_STEP_HI;
                  r_clk      <= 1'b1;
                  r_clk_rise <= 1'b1;
               end
            end
            CLK_ST_RUNNING: begin
               r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
               // A stop landing on the high-phase terminal ends that phase now.
               if (w_ss_press && (!r_clk || w_term)) begin
                  r_state <= CLK_ST_STOPPED;
                  r_cnt   <= '0;
                  r_clk   <= 1'b0;
               end else if (w_ss_press) begin
                  r_state <= CLK_ST_STOPPING;
               end else if (w_term) begin
                  r_clk      <= ~r_clk;
                  r_clk_rise <= ~r_clk;
               end
            end
            CLK_ST_STOPPING: begin
               r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
               if (w_term) begin
                  r_clk   <= 1'b0;
                  r_state <= CLK_ST_STOPPED;
               end
            end
            CLK_ST_STEP_HI: begin
               r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
               if (w_term) begin
                  r_clk   <= 1'b0;
                  r_state <= CLK_ST_STEP_LO;
               end
            end
            CLK_ST_STEP_LO: begin
               r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
               if (w_term) r_state <= CLK_ST_STOPPED;
            end
            default: begin
               r_state <= CLK_ST_STOPPED;
               r_cnt   <= '0;
               r_clk   <= 1'b0;
            end
         endcase
      end
   end

   assign clk       = r_clk;
   assign clk_rise  = r_clk_rise;
   assign speed     = r_speed;
   assign running   = (r_state == CLK_ST_RUNNING) || (r_state == CLK_ST_STOPPING);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_clock_generator.sv
// Directed bench for clock_generator with short debounce and divider settings.
module tb_clock_generator;
   import clock_generator_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       ss_btn = 1'b0;
   logic       step_btn = 1'b0;
   logic       speed_btn = 1'b0;
   logic       clk;
   logic       clk_rise;
   logic       running;
   logic [1:0] speed;
   clk_state_e dbg_state;

   int checks = 0;
   int errors = 0;

   clock_generator #(
      .DEBOUNCE_CYCLES(4), .DIV0(8), .DIV1(4), .DIV2(2), .DIV3(1), .CNT_W(25)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .clk_start_stop_i(ss_btn), .clk_step_i(step_btn), .clk_speed_i(speed_btn),
      .clk(clk), .clk_rise(clk_rise), .running(running), .speed(speed),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_rise(output int n);
      n = 0;
      while (clk_rise !== 1'b1 && n < 60) begin
         tick(1);
         n++;
      end
   endtask

   task automatic count_rises(input int cycles, output int r);
      r = 0;
      for (int i = 0; i < cycles; i++) begin
         tick(1);
         if (clk_rise === 1'b1) r++;
      end
   endtask

   task automatic speed_press();
      speed_btn = 1'b1;
      tick(6);
      speed_btn = 1'b0;
      tick(8);
   endtask

   initial begin
      int n;
      int r;

      // reset state
      tick(2);
      check("rst_clk", clk, 0);
      check("rst_clk_rise", clk_rise, 0);
      check("rst_running", running, 0);
      check("rst_speed", speed, 0);
      check("rst_state", dbg_state, CLK_ST_STOPPED);
      rst_i = 1'b1;
      tick(3);
      check("post_rst_state", dbg_state, CLK_ST_STOPPED);

      // bouncing start/stop, then held
      for (int i = 0; i < 2; i++) begin
         ss_btn = 1'b1; tick(2);
         ss_btn = 1'b0; tick(2);
      end
      check("bounce_no_event", running, 0);
      ss_btn = 1'b1;
      n = 0;
      while (running !== 1'b1 && n < 40) begin tick(1); n++; end
      check("press_latency", n, 7);
      n = 0;
      while (clk !== 1'b1 && n < 40) begin tick(1); n++; end
      check("first_rise_delay", n, 8);
      check("first_rise_strobe", clk_rise, 1);
      ss_btn = 1'b0;
      tick(1);
      check("rise_one_cycle", clk_rise, 0);
      n = 1;
      while (clk_rise !== 1'b1 && n < 40) begin tick(1); n++; end
      check("period_speed0", n, 16);
      check("hold_one_event", running, 1);

      // stop requested while clk high at cnt=3
      tick(13);
      ss_btn = 1'b1;
      tick(3);
      check("rise_before_stop", clk_rise, 1);
      tick(4);
      check("stopping_state", dbg_state, CLK_ST_STOPPING);
      check("stopping_running", running, 1);
      check("stopping_clk", clk, 1);
      tick(3);
      check("stopping_hold_hi", clk, 1);
      tick(1);
      check("stop_clk_low", clk, 0);
      check("stop_state", dbg_state, CLK_ST_STOPPED);
      check("stop_running", running, 0);
      ss_btn = 1'b0;
      count_rises(30, r);
      check("stop_no_rise", r, 0);

      // single step, with a second press during the high phase
      step_btn = 1'b1;
      tick(6);
      step_btn = 1'b0;
      check("step_pre_clk", clk, 0);
      tick(1);
      check("step_clk_hi", clk, 1);
      check("step_rise", clk_rise, 1);
      check("step_state_hi", dbg_state, CLK_ST_STEP_HI);
      tick(1);
      check("step_rise_once", clk_rise, 0);
      tick(4);
      step_btn = 1'b1;
      tick(2);
      check("step_hi_last", clk, 1);
      tick(1);
      check("step_fall", clk, 0);
      check("step_state_lo", dbg_state, CLK_ST_STEP_LO);
      tick(3);
      step_btn = 1'b0;
      tick(4);
      check("step_lo_last", dbg_state, CLK_ST_STEP_LO);
      tick(1);
      check("step_done", dbg_state, CLK_ST_STOPPED);
      count_rises(27, r);
      check("step_no_extra", r, 0);
      check("step_clk_end", clk, 0);

      // simultaneous start/stop and step in STOPPED
      ss_btn = 1'b1;
      step_btn = 1'b1;
      tick(7);
      check("simul_running", dbg_state, CLK_ST_RUNNING);
      check("simul_no_step", clk, 0);
      n = 0;
      while (clk !== 1'b1 && n < 40) begin tick(1); n++; end
      check("simul_rise_delay", n, 8);
      check("simul_rise_strobe", clk_rise, 1);
      ss_btn = 1'b0;
      step_btn = 1'b0;
      tick(8);

      // speed cycling while running
      speed_press();
      check("speed_1", speed, 1);
      speed_press();
      check("speed_2", speed, 2);
      speed_press();
      check("speed_3", speed, 3);
      wait_rise(n);
      check("speed3_rise_found", clk_rise, 1);
      tick(1);
      check("speed3_gap", clk_rise, 0);
      tick(1);
      check("speed3_period", clk_rise, 1);
      speed_press();
      check("speed_wrap", speed, 0);

      // speed 0 -> 1 at cnt=5 of a low phase ends it on the next cycle
      wait_rise(n);
      check("speed0_rise_found", clk_rise, 1);
      tick(7);
      check("speed0_hi_end", clk, 1);
      speed_btn = 1'b1;
      tick(6);
      speed_btn = 1'b0;
      check("speed_before_change", speed, 0);
      tick(1);
      check("speed_changed", speed, 1);
      check("no_rise_yet", clk_rise, 0);
      tick(1);
      check("short_phase_rise", clk_rise, 1);
      tick(1);
      n = 1;
      while (clk_rise !== 1'b1 && n < 40) begin tick(1); n++; end
      check("period_speed1", n, 8);

      // asynchronous reset in the middle of a high phase
      tick(1);
      check("pre_reset_clk", clk, 1);
      rst_i = 1'b0;
      #1;
      check("async_rst_clk", clk, 0);
      check("async_rst_running", running, 0);
      check("async_rst_speed", speed, 0);
      check("async_rst_state", dbg_state, CLK_ST_STOPPED);
      tick(2);
      rst_i = 1'b1;
      count_rises(30, r);
      check("after_rst_no_rise", r, 0);
      check("after_rst_state", dbg_state, CLK_ST_STOPPED);
      check("after_rst_clk", clk, 0);

      // report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
